// File: rtl/satatx_framer_pkg.sv
// Shared SATA link constants, frame-builder state type and the dword scramble/CRC
// step functions used by both the TX framer and the RX descrambler/CRC checker.
package satatx_framer_pkg;

  localparam logic [15:0] SATA_SCR_POLY = 16'ha011;
  localparam logic [15:0] SATA_SCR_INIT = 16'hffff;
  localparam logic [31:0] SATA_CRC_POLY = 32'h04c11db7;
  localparam logic [31:0] SATA_CRC_INIT = 32'h52325032;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_CRC  = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] prn;
    logic [15:0] fill;
  } scr_step_t;

  // prn[0] is the first bit out of the LFSR and lands in bit 0 of the dword.
  function automatic scr_step_t sata_scramble(input logic [15:0] fill,
                                              input logic [15:0] poly);
    scr_step_t   r;
    logic [15:0] f;
    f = fill;
    r = '0;
    for (int k = 0; k < 32; k++) begin
      r.prn[k] = f[15];
      f = {f[14:0], 1'b0} ^ (f[15] ? poly : 16'h0000);
    end
    r.fill = f;
    return r;
  endfunction

  function automatic logic [31:0] sata_crc32_update(input logic [31:0] crc,
                                                    input logic [31:0] data,
                                                    input logic [31:0] poly);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int b = 31; b >= 0; b--) begin
      fb = c[31] ^ data[b];
      c  = {c[30:0], 1'b0} ^ (fb ? poly : 32'h0);
    end
    return c;
  endfunction

endpackage

// File: rtl/sata_crc32.sv
// Combinational one-dword SATA CRC-32 step (MSB first, non-reflected); latency 0.
module sata_crc32
  import satatx_framer_pkg::*;
#(
  parameter logic [31:0] CRC_POLY = SATA_CRC_POLY
) (
  input  logic [31:0] i_crc,
  input  logic [31:0] i_data,
  output logic [31:0] o_crc
);

  assign o_crc = sata_crc32_update(i_crc, i_data, CRC_POLY);

endmodule

// File: rtl/satatx_framer.sv
// SATA TX payload framer: CRC-32 over the clear payload, CRC dword appended with TLAST,
// then everything scrambled; one-cycle registered output, input stalls while CRC pending.
module satatx_framer
  import satatx_framer_pkg::*;
#(
  parameter logic [15:0] POLYNOMIAL   = SATA_SCR_POLY,
  parameter logic [15:0] INITIAL      = SATA_SCR_INIT,
  parameter logic [31:0] CRC_POLY     = SATA_CRC_POLY,
  parameter logic [31:0] CRC_INIT     = SATA_CRC_INIT,
  parameter bit          OPT_LOWPOWER = 1'b1
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESETN,
  input  logic        i_cfg_scrambler_en,
  input  logic        S_AXIS_TVALID,
  output logic        S_AXIS_TREADY,
  input  logic [31:0] S_AXIS_TDATA,
  input  logic        S_AXIS_TLAST,
  output logic        M_AXIS_TVALID,
  input  logic        M_AXIS_TREADY,
  output logic [31:0] M_AXIS_TDATA,
  output logic        M_AXIS_TLAST
);

  state_t      state_q, state_d;
  logic [15:0] fill_q, fill_d;
  logic [31:0] crc_q, crc_d;
  logic        scr_en_q, scr_en_d;
  logic        m_vld_q, m_vld_d;
  logic [31:0] m_dat_q, m_dat_d;
  logic        m_last_q, m_last_d;

  logic [31:0] crc_next;
  scr_step_t   scr;
  logic        slot_free;
  logic        s_rdy;
  logic        accept;
  logic        scr_use;

  sata_crc32 #(
    .CRC_POLY(CRC_POLY)
  ) u_crc (
    .i_crc (crc_q),
    .i_data(S_AXIS_TDATA),
    .o_crc (crc_next)
  );

  assign scr       = sata_scramble(fill_q, POLYNOMIAL);
  assign slot_free = !m_vld_q || M_AXIS_TREADY;
  assign s_rdy     = (state_q != ST_CRC) && slot_free;
  assign accept    = S_AXIS_TVALID && s_rdy;
  // The first beat must already honour the new enable, before it lands in scr_en_q.
  assign scr_use   = (state_q == ST_IDLE) ? i_cfg_scrambler_en : scr_en_q;

  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    crc_d    = crc_q;
    scr_en_d = scr_en_q;
    m_vld_d  = m_vld_q;
    m_dat_d  = m_dat_q;
    m_last_d = m_last_q;

    if (slot_free) begin
      m_vld_d = 1'b0;
      if (OPT_LOWPOWER) begin
        m_dat_d  = 32'h0;
        m_last_d = 1'b0;
      end
    end

    if (accept) begin
      m_vld_d  = 1'b1;
      m_dat_d  = scr_use ? (S_AXIS_TDATA ^ scr.prn) : S_AXIS_TDATA;
      m_last_d = 1'b0;
      fill_d   = scr.fill;
      crc_d    = crc_next;
      if (state_q == ST_IDLE) begin
        scr_en_d = i_cfg_scrambler_en;
      end
      state_d = S_AXIS_TLAST ? ST_CRC : ST_DATA;
    end else if ((state_q == ST_CRC) && slot_free) begin
      m_vld_d  = 1'b1;
      m_dat_d  = scr_en_q ? (crc_q ^ scr.prn) : crc_q;
      m_last_d = 1'b1;
      fill_d   = INITIAL;
      crc_d    = CRC_INIT;
      state_d  = ST_IDLE;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state_q  <= ST_IDLE;
      fill_q   <= INITIAL;
      crc_q    <= CRC_INIT;
      scr_en_q <= 1'b0;
      m_vld_q  <= 1'b0;
      m_dat_q  <= 32'h0;
      m_last_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      crc_q    <= crc_d;
      scr_en_q <= scr_en_d;
      m_vld_q  <= m_vld_d;
      m_dat_q  <= m_dat_d;
      m_last_q <= m_last_d;
    end
  end

  assign S_AXIS_TREADY = s_rdy;
  assign M_AXIS_TVALID = m_vld_q;
  assign M_AXIS_TDATA  = m_dat_q;
  assign M_AXIS_TLAST  = m_last_q;

endmodule

// File: tb/tb_satatx_framer.sv
// Self-checking bench for satatx_framer against a bit-serial reference of the
// SATA scrambler stream and CRC-32, with random payloads and backpressure.
module tb_satatx_framer;

  logic        clk = 1'b0;
  logic        S_AXI_ARESETN;
  logic        i_cfg_scrambler_en;
  logic        S_AXIS_TVALID;
  logic        S_AXIS_TREADY;
  logic [31:0] S_AXIS_TDATA;
  logic        S_AXIS_TLAST;
  logic        M_AXIS_TVALID;
  logic        M_AXIS_TREADY;
  logic [31:0] M_AXIS_TDATA;
  logic        M_AXIS_TLAST;

  satatx_framer dut (
    .S_AXI_ACLK        (clk),
    .S_AXI_ARESETN     (S_AXI_ARESETN),
    .i_cfg_scrambler_en(i_cfg_scrambler_en),
    .S_AXIS_TVALID     (S_AXIS_TVALID),
    .S_AXIS_TREADY     (S_AXIS_TREADY),
    .S_AXIS_TDATA      (S_AXIS_TDATA),
    .S_AXIS_TLAST      (S_AXIS_TLAST),
    .M_AXIS_TVALID     (M_AXIS_TVALID),
    .M_AXIS_TREADY     (M_AXIS_TREADY),
    .M_AXIS_TDATA      (M_AXIS_TDATA),
    .M_AXIS_TLAST      (M_AXIS_TLAST)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_low = 0;
  bit rand_rdy = 1'b0;
  bit prev_stall = 1'b0;
  logic [32:0] prev_out = '0;

  logic [31:0] pl_q[$];
  logic [31:0] prn_q[$];
  logic [32:0] exp_q[$];
  logic [32:0] cap_q[$];
  int          cap_cyc[$];

  initial begin
    M_AXIS_TREADY = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      M_AXIS_TREADY = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: records every transfer and checks hold stability during stalls.
  always @(negedge clk) begin
    cyc++;
    if (S_AXI_ARESETN && !S_AXIS_TREADY) rdy_low++;
    if (S_AXI_ARESETN && prev_stall) begin
      checks++;
      if (M_AXIS_TVALID !== 1'b1 || {M_AXIS_TLAST, M_AXIS_TDATA} !== prev_out) begin
        errors++;
        $display("FAIL hold_stable: got vld=%b last/data=%h, required vld=1 last/data=%h",
                 M_AXIS_TVALID, {M_AXIS_TLAST, M_AXIS_TDATA}, prev_out);
      end
    end
    if (M_AXIS_TVALID && M_AXIS_TREADY) begin
      cap_q.push_back({M_AXIS_TLAST, M_AXIS_TDATA});
      cap_cyc.push_back(cyc);
    end
    prev_stall = S_AXI_ARESETN && M_AXIS_TVALID && !M_AXIS_TREADY;
    prev_out   = {M_AXIS_TLAST, M_AXIS_TDATA};
  end

  // Reference CRC: shift the message in one bit at a time, MSB first.
  function automatic logic [31:0] ref_crc_step(input logic [31:0] c_in, input logic [31:0] d);
    logic [31:0] c;
    logic        fb;
    c = c_in;
    for (int b = 31; b >= 0; b--) begin
      fb = c[31] ^ d[b];
      c  = {c[30:0], 1'b0};
      if (fb) c = c ^ 32'h04c11db7;
    end
    return c;
  endfunction

  // Expected output of one frame held in pl_q: one continuous PRN bit stream from the
  // seed, chopped into dwords, covering the payload and then the CRC.
  task automatic model_frame(input bit en);
    logic [15:0] f;
    logic [31:0] c;
    logic [31:0] p;
    bit          bits[$];
    int          n;
    n = pl_q.size();
    f = 16'hffff;
    c = 32'h52325032;
    for (int k = 0; k < (n + 1) * 32; k++) begin
      bits.push_back(f[15]);
      f = {f[14:0], 1'b0} ^ (f[15] ? 16'ha011 : 16'h0000);
    end
    for (int i = 0; i < n; i++) c = ref_crc_step(c, pl_q[i]);
    for (int j = 0; j <= n; j++) begin
      p = '0;
      for (int b = 0; b < 32; b++) p[b] = bits[j * 32 + b];
      prn_q.push_back(p);
      if (j < n) exp_q.push_back({1'b0, en ? (pl_q[j] ^ p) : pl_q[j]});
      else       exp_q.push_back({1'b1, en ? (c ^ p) : c});
    end
  endtask

  task automatic clear_all();
    pl_q.delete();
    prn_q.delete();
    exp_q.delete();
    cap_q.delete();
    cap_cyc.delete();
  endtask

  task automatic idle_input();
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TDATA  = 32'h0;
    S_AXIS_TLAST  = 1'b0;
  endtask

  // Presents one beat and returns just after the clock edge that accepted it.
  task automatic drive_beat(input logic [31:0] d, input logic last);
    int n;
    S_AXIS_TVALID = 1'b1;
    S_AXIS_TDATA  = d;
    S_AXIS_TLAST  = last;
    n = 0;
    @(negedge clk);
    while (!S_AXIS_TREADY && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL drive_timeout: S_AXIS_TREADY stayed %b, required 1", S_AXIS_TREADY);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cap(input int n);
    int t;
    t = 0;
    while (cap_q.size() < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) begin
      checks++;
      errors++;
      $display("FAIL wait_output: got %0d beats, required %0d", cap_q.size(), n);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    S_AXI_ARESETN = 1'b0;
    i_cfg_scrambler_en = 1'b0;
    idle_input();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (M_AXIS_TVALID !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b, required 0", M_AXIS_TVALID); end
    checks++;
    if (M_AXIS_TDATA !== 32'h0) begin errors++; $display("FAIL reset_tdata: got %h, required 00000000", M_AXIS_TDATA); end
    checks++;
    if (M_AXIS_TLAST !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b, required 0", M_AXIS_TLAST); end
    checks++;
    if (S_AXIS_TREADY !== 1'b1) begin errors++; $display("FAIL reset_tready: got %b, required 1", S_AXIS_TREADY); end
    S_AXI_ARESETN = 1'b1;
    @(posedge clk);
    #1;
    clear_all();
  endtask

  task automatic test_single_zero();
    clear_all();
    pl_q.push_back(32'h0);
    model_frame(1'b1);
    i_cfg_scrambler_en = 1'b1;
    drive_beat(32'h0, 1'b1);
    idle_input();
    wait_cap(2);
    checks++;
    if (cap_q.size() !== 2) begin errors++; $display("FAIL single_count: got %0d, required 2", cap_q.size()); end
    if (cap_q.size() >= 2) begin
      checks++;
      if (cap_q[0] !== {1'b0, 32'hc2d2768d}) begin
        errors++; $display("FAIL single_first_prn: got %h, required 0c2d2768d", cap_q[0]);
      end
      checks++;
      if (cap_q[1] !== exp_q[1]) begin
        errors++; $display("FAIL single_crc: got %h, required %h", cap_q[1], exp_q[1]);
      end
      checks++;
      if (cap_cyc[1] - cap_cyc[0] !== 1) begin
        errors++; $display("FAIL single_crc_gap: got %0d, required 1", cap_cyc[1] - cap_cyc[0]);
      end
    end
  endtask

  task automatic test_scr_disabled();
    clear_all();
    pl_q = '{32'h01020304, 32'h05060708, 32'h090a0b0c, 32'h0d0e0f10};
    model_frame(1'b0);
    i_cfg_scrambler_en = 1'b0;
    rdy_low = 0;
    for (int i = 0; i < 4; i++) drive_beat(pl_q[i], i == 3);
    idle_input();
    wait_cap(5);
    checks++;
    if (cap_q.size() !== 5) begin errors++; $display("FAIL plain_count: got %0d, required 5", cap_q.size()); end
    for (int i = 0; i < 5 && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL plain_beat[%0d]: got %h, required %h", i, cap_q[i], exp_q[i]);
      end
    end
    for (int i = 0; i < 4 && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i][31:0] !== pl_q[i]) begin
        errors++; $display("FAIL plain_passthru[%0d]: got %h, required %h", i, cap_q[i][31:0], pl_q[i]);
      end
    end
    checks++;
    if (rdy_low !== 1) begin errors++; $display("FAIL plain_tready_low: got %0d cycles, required 1", rdy_low); end
  endtask

  task automatic test_backpressure();
    logic [31:0] r;
    logic [31:0] d;
    clear_all();
    for (int i = 0; i < 64; i++) pl_q.push_back($urandom);
    model_frame(1'b1);
    i_cfg_scrambler_en = 1'b1;
    rand_rdy = 1'b1;
    for (int i = 0; i < 64; i++) drive_beat(pl_q[i], i == 63);
    idle_input();
    wait_cap(65);
    rand_rdy = 1'b0;
    checks++;
    if (cap_q.size() !== 65) begin errors++; $display("FAIL bp_count: got %0d, required 65", cap_q.size()); end
    for (int i = 0; i < 65 && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL bp_beat[%0d]: got %h, required %h", i, cap_q[i], exp_q[i]);
      end
    end
    // RX side: strip the scrambler, then the CRC over payload plus CRC dword leaves zero.
    r = 32'h52325032;
    for (int i = 0; i < 65 && i < cap_q.size(); i++) begin
      d = cap_q[i][31:0] ^ prn_q[i];
      r = ref_crc_step(r, d);
      if (i < 64) begin
        checks++;
        if (d !== pl_q[i]) begin
          errors++; $display("FAIL bp_roundtrip[%0d]: got %h, required %h", i, d, pl_q[i]);
        end
      end
    end
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL bp_residue: got %h, required 00000000", r); end
  endtask

  task automatic test_cfg_toggle();
    logic [31:0] a1[$];
    logic [31:0] a2[$];
    clear_all();
    for (int i = 0; i < 6; i++) pl_q.push_back($urandom);
    model_frame(1'b1);
    a1 = pl_q;
    pl_q.delete();
    for (int i = 0; i < 5; i++) pl_q.push_back($urandom);
    model_frame(1'b0);
    a2 = pl_q;
    for (int i = 0; i < 6; i++) begin
      i_cfg_scrambler_en = (i == 0) ? 1'b1 : 1'(i % 2);
      drive_beat(a1[i], i == 5);
    end
    idle_input();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      i_cfg_scrambler_en = (i == 0) ? 1'b0 : 1'(i % 2);
      drive_beat(a2[i], i == 4);
    end
    idle_input();
    wait_cap(13);
    checks++;
    if (cap_q.size() !== 13) begin errors++; $display("FAIL cfg_count: got %0d, required 13", cap_q.size()); end
    for (int i = 0; i < 13 && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL cfg_beat[%0d]: got %h, required %h", i, cap_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int lasts;
    clear_all();
    i_cfg_scrambler_en = 1'b1;
    for (int i = 0; i < 3; i++) drive_beat($urandom, 1'b0);
    S_AXIS_TDATA  = $urandom;
    S_AXI_ARESETN = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (M_AXIS_TVALID !== 1'b0) begin errors++; $display("FAIL rst_mid_tvalid: got %b, required 0", M_AXIS_TVALID); end
    S_AXI_ARESETN = 1'b1;
    idle_input();
    repeat (6) @(posedge clk);
    #1;
    lasts = 0;
    foreach (cap_q[i]) if (cap_q[i][32]) lasts++;
    checks++;
    if (cap_q.size() !== 3) begin errors++; $display("FAIL rst_mid_count: got %0d, required 3", cap_q.size()); end
    checks++;
    if (lasts !== 0) begin errors++; $display("FAIL rst_mid_no_crc: got %0d TLAST beats, required 0", lasts); end
    clear_all();
    drive_beat(32'h0, 1'b1);
    idle_input();
    wait_cap(2);
    checks++;
    if (cap_q.size() < 1 || cap_q[0] !== {1'b0, 32'hc2d2768d}) begin
      errors++;
      $display("FAIL rst_mid_restart: got %h, required 0c2d2768d", cap_q.size() > 0 ? cap_q[0] : 33'h0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1[$];
    logic [31:0] a2[$];
    clear_all();
    for (int i = 0; i < 5; i++) pl_q.push_back($urandom);
    model_frame(1'b1);
    a1 = pl_q;
    pl_q.delete();
    for (int i = 0; i < 3; i++) pl_q.push_back($urandom);
    model_frame(1'b1);
    a2 = pl_q;
    i_cfg_scrambler_en = 1'b1;
    for (int i = 0; i < 5; i++) drive_beat(a1[i], i == 4);
    for (int i = 0; i < 3; i++) drive_beat(a2[i], i == 2);
    idle_input();
    wait_cap(10);
    checks++;
    if (cap_q.size() !== 10) begin errors++; $display("FAIL b2b_count: got %0d, required 10", cap_q.size()); end
    for (int i = 0; i < 10 && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL b2b_beat[%0d]: got %h, required %h", i, cap_q[i], exp_q[i]);
      end
    end
    if (cap_q.size() == 10) begin
      checks++;
      if (cap_cyc[9] - cap_cyc[0] !== 9) begin
        errors++; $display("FAIL b2b_span: got %0d cycles, required 9", cap_cyc[9] - cap_cyc[0]);
      end
      checks++;
      if (cap_cyc[9] - cap_cyc[8] !== 1) begin
        errors++; $display("FAIL b2b_tlast_gap: got %0d, required 1", cap_cyc[9] - cap_cyc[8]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_zero();
    test_scr_disabled();
    test_backpressure();
    test_cfg_toggle();
    test_reset_midframe();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
